// File: rtl/core_bus_adapter.sv
// Arbitrates N_CH core request channels round-robin onto one Wishbone classic master port,
// with an optional bus timeout and a configurable registered delay before the core-side ack.
module core_bus_adapter #(
    parameter int N_CH      = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int ACK_DELAY = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic                         clk_core,
    input  logic                         rst_core,
    input  logic [N_CH-1:0]              ch_req,
    input  logic [N_CH-1:0]              ch_we,
    input  logic [N_CH*ADDR_W-1:0]       ch_addr,
    input  logic [N_CH*DATA_W-1:0]       ch_wdata,
    input  logic [N_CH*(DATA_W/8)-1:0]   ch_mask,
    output logic [N_CH-1:0]              ch_ack,
    output logic [N_CH-1:0]              ch_err,
    output logic [DATA_W-1:0]            ch_rdata,
    output logic                         wb_cyc,
    output logic                         wb_stb,
    output logic                         wb_we,
    output logic [ADDR_W-1:0]            wb_adr,
    output logic [DATA_W-1:0]            wb_dat_o,
    output logic [DATA_W/8-1:0]          wb_sel,
    input  logic [DATA_W-1:0]            wb_dat_i,
    input  logic                         wb_ack
);

    localparam int              SEL_W    = DATA_W / 8;
    localparam int              GW       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [GW-1:0]   LAST_CH  = GW'(N_CH - 1);
    localparam logic [15:0]     TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [1:0]      DLY      = 2'(ACK_DELAY);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t          state, state_nxt;
    logic [GW-1:0]   last_grant, grant_nxt;
    logic            any_req;
    logic            tmo_hit;
    logic            resp_done;
    logic [15:0]     tmo_cnt;
    logic [1:0]      dly_cnt;
    logic            err_flag;
    logic            req_we;
    int              idx;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        any_req   = 1'b0;
        grant_nxt = last_grant;
        idx       = 0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = (int'(last_grant) + i) % N_CH;
            if (!any_req && ch_req[idx[GW-1:0]]) begin
                any_req   = 1'b1;
                grant_nxt = idx[GW-1:0];
            end
        end
    end

    assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign resp_done = (dly_cnt == DLY);

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = BUS;
            BUS:     if (wb_ack || tmo_hit) state_nxt = RESP;
            RESP:    if (resp_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The ack pulse comes from the last RESP cycle, so it is exactly one cycle wide.
    always_comb begin
        wb_cyc = (state == BUS);
        wb_stb = (state == BUS);
        wb_we  = (state == BUS) && req_we;
        ch_ack = '0;
        ch_err = '0;
        if (state == RESP && resp_done) begin
            ch_ack[last_grant] = 1'b1;
            ch_err[last_grant] = err_flag;
        end
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            last_grant <= LAST_CH;
            req_we     <= 1'b0;
            wb_adr     <= '0;
            wb_dat_o   <= '0;
            wb_sel     <= '0;
            ch_rdata   <= '0;
            tmo_cnt    <= '0;
            dly_cnt    <= '0;
            err_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_grant <= grant_nxt;
                        req_we     <= ch_we[grant_nxt];
                        wb_adr     <= ch_addr[grant_nxt*ADDR_W +: ADDR_W];
                        wb_dat_o   <= ch_wdata[grant_nxt*DATA_W +: DATA_W];
                        wb_sel     <= ch_mask[grant_nxt*SEL_W +: SEL_W];
                        tmo_cnt    <= '0;
                    end
                end
                BUS: begin
                    // A slave ack in the timeout cycle still completes normally.
                    if (wb_ack) begin
                        ch_rdata <= wb_dat_i;
                        err_flag <= 1'b0;
                        dly_cnt  <= '0;
                    end else if (tmo_hit) begin
                        ch_rdata <= '0;
                        err_flag <= 1'b1;
                        dly_cnt  <= '0;
                    end else if (TIMEOUT != 0) begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                RESP:    dly_cnt <= dly_cnt + 2'd1;
                default: ;
            endcase
        end
    end

endmodule
